// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-transfer APB requester for two 8-bit completers
// Purpose: converts a valid/ready command into one APB SETUP/ACCESS transfer at a
//   time and returns a one-cycle response pulse carrying read data and abort status.
// Optional feature: define APB_TIMEOUT_EN to bound ACCESS-phase waiting to
//   TIMEOUT_CYCLES wait cycles. Without it ACCESS waits forever and rsp_err is 0.
// Ports:
//   PCLK, PRESETn                          clock, asynchronous active-low reset
//   cmd_valid, cmd_ready                   command handshake
//   cmd_write, cmd_addr, cmd_wdata         command fields, cmd_addr[8] picks completer
//   rsp_valid, rsp_rdata, rsp_err          completion pulse and result
//   PSEL1, PSEL2, PENABLE, PWRITE          APB control toward the completers
//   PADDR, PWDATA                          APB address and write data
//   PREADY1, PREADY2, PRDATA1, PRDATA2     completer ready and read data
module apb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [8:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic       PREADY1,
  input  logic       PREADY2,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0] state;
  logic       sel2;
  logic       pready_sel;
  logic [7:0] prdata_sel;
  logic       abort;

  // Only the addressed completer is listened to; the other one may do anything.
  assign pready_sel = sel2 ? PREADY2 : PREADY1;
  assign prdata_sel = sel2 ? PRDATA2 : PRDATA1;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] LIMIT_M1 = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;
  logic       err_q;

  // Abort on the wait cycle whose increment would bring the count to the limit.
  assign abort = (state == ACCESS) && !pready_sel && (wait_cnt == LIMIT_M1);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      if (state == SETUP) begin
        wait_cnt <= 8'd0;
      end else if (state == ACCESS && !pready_sel) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (state == ACCESS) begin
        if (pready_sel) begin
          err_q <= 1'b0;
        end else if (abort) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign rsp_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign abort   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      sel2      <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= 8'h00;
      PWDATA    <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr[7:0];
            PWDATA    <= cmd_wdata;
            sel2      <= cmd_addr[8];
            PSEL1     <= ~cmd_addr[8];
            PSEL2     <= cmd_addr[8];
            cmd_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready_sel || abort) begin
            // Writes and aborted transfers report zero data.
            rsp_rdata <= (pready_sel && !PWRITE) ? prdata_sel : 8'h00;
            rsp_valid <= 1'b1;
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          PSEL1     <= 1'b0;
          PSEL2     <= 1'b0;
          PENABLE   <= 1'b0;
          cmd_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
